// File: rtl/uart_rx_fifo_if.sv
// Peripheral-bus bundle between the CPU address decode and the UART receive buffer.
// The master side drives select/address/write data/qualifiers; the slave side returns read data.
interface uart_rx_fifo_if;
    logic        m_sel;
    logic [3:0]  m_addr;
    logic [31:0] m_data_i;
    logic [31:0] m_data_o;
    logic        m_rd;
    logic        m_wr;

    modport master (
        output m_sel,
        output m_addr,
        output m_data_i,
        output m_rd,
        output m_wr,
        input  m_data_o
    );

    modport slave (
        input  m_sel,
        input  m_addr,
        input  m_data_i,
        input  m_rd,
        input  m_wr,
        output m_data_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with DATA/STATUS/CONTROL registers and a level-triggered fill-threshold interrupt.
// Bytes strobed by the receiver are queued; the CPU pops one byte per contiguous DATA read interval.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk_i,
    input  logic           rstn,
    input  logic [7:0]     rx_data_i,
    input  logic           rx_valid_i,
    input  logic           rx_ferr_i,
    uart_rx_fifo_if.slave  bus,
    output logic           irq_o
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic                  ovr_r;
    logic                  ferr_r;
    logic                  ien_r;
    logic [5:0]            thresh_r;
    logic                  rd_prev_r;
    logic                  irq_r;

    logic                  rd_sel_s;
    logic                  ctrl_wr_s;
    logic                  flush_s;
    logic                  clear_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [5:0]            thresh_eff_s;
    logic                  irq_next_s;
    logic [7:0]            head_s;
    logic [31:0]           status_s;
    logic [31:0]           rdata_s;

    // Decode bus strobes and derive push/pop/overflow qualifiers for this cycle.
    always_comb begin
        rd_sel_s     = bus.m_sel & (bus.m_addr == 4'd0) & bus.m_rd;
        ctrl_wr_s    = bus.m_sel & (bus.m_addr == 4'd2) & bus.m_wr;
        flush_s      = ctrl_wr_s & bus.m_data_i[0];
        clear_s      = ctrl_wr_s & bus.m_data_i[1];
        empty_s      = (level_r == LVL_ZERO);
        full_s       = (level_r == LVL_FULL);
        // Only the first cycle of a held read pops; an empty FIFO ignores it.
        pop_s        = rd_sel_s & ~rd_prev_r & ~empty_s;
        push_s       = rx_valid_i & (~full_s | pop_s);
        drop_s       = rx_valid_i & full_s & ~pop_s & ~flush_s;
        thresh_eff_s = (thresh_r == 6'd0) ? 6'd1 : thresh_r;
        irq_next_s   = ien_r & (6'(level_r) >= thresh_eff_s);
    end

    // Byte storage; intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_s & ~flush_s) begin
            mem_r[wr_ptr_r] <= rx_data_i;
        end
    end

    // Pointers and fill level; a flush overrides any concurrent push or pop.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (clear_s) begin
                ovr_r <= 1'b0;
            end
            if (rx_valid_i & rx_ferr_i) begin
                ferr_r <= 1'b1;
            end else if (clear_s) begin
                ferr_r <= 1'b0;
            end
        end
    end

    // Stored control fields, read-edge tracker and registered interrupt.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            ien_r     <= 1'b0;
            thresh_r  <= 6'd1;
            rd_prev_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ien_r    <= bus.m_data_i[2];
                thresh_r <= bus.m_data_i[13:8];
            end
            rd_prev_r <= rd_sel_s;
            irq_r     <= irq_next_s;
        end
    end

    // Combinational register read mux.
    always_comb begin
        head_s   = empty_s ? 8'd0 : mem_r[rd_ptr_r];
        status_s = 32'd0;
        status_s[0] = ~empty_s;
        status_s[1] = full_s;
        status_s[2] = ovr_r;
        status_s[3] = ferr_r;
        status_s[DEPTH_LOG2+8:8] = level_r;
        rdata_s  = 32'd0;
        if (bus.m_sel) begin
            case (bus.m_addr)
                4'd0:    rdata_s = {24'd0, head_s};
                4'd1:    rdata_s = status_s;
                4'd2:    rdata_s = {18'd0, thresh_r, 5'd0, ien_r, 2'd0};
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.m_data_o = rdata_s;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase including an asynchronous reset.
module tb_uart_rx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic       clk_i      = 1'b0;
    logic       rstn       = 1'b0;
    logic [7:0] rx_data_i  = 8'd0;
    logic       rx_valid_i = 1'b0;
    logic       rx_ferr_i  = 1'b0;
    logic       irq_o;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk_i      (clk_i),
        .rstn       (rstn),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ferr_i  (rx_ferr_i),
        .bus        (bus),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned mq[$];
    bit  m_ovr = 1'b0, m_ferr = 1'b0, m_ien = 1'b0, m_irq = 1'b0, m_rd_prev = 1'b0;
    int  m_thresh = 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_rdata();
        int s;
        if (bus.m_sel !== 1'b1) return 32'd0;
        case (bus.m_addr)
            4'd0: return (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
            4'd1: begin
                s = 0;
                if (mq.size() > 0) s = s | 1;
                if (mq.size() == DEPTH) s = s | 2;
                if (m_ovr) s = s | 4;
                if (m_ferr) s = s | 8;
                s = s | (mq.size() << 8);
                return 32'(s);
            end
            4'd2: return 32'((m_thresh << 8) | (int'(m_ien) << 2));
            default: return 32'd0;
        endcase
    endfunction

    // Model update on each active edge / async reset
    initial forever begin
        @(posedge clk_i or negedge rstn);
        if (!rstn) begin
            mq.delete();
            m_ovr = 1'b0; m_ferr = 1'b0; m_ien = 1'b0;
            m_thresh = 1; m_irq = 1'b0; m_rd_prev = 1'b0;
        end else begin
            bit rd_sel, wr_ctl, fl, cl;
            rd_sel = bus.m_sel && bus.m_addr == 4'd0 && bus.m_rd;
            wr_ctl = bus.m_sel && bus.m_addr == 4'd2 && bus.m_wr;
            fl = wr_ctl && bus.m_data_i[0];
            cl = wr_ctl && bus.m_data_i[1];
            m_irq = m_ien && (mq.size() >= ((m_thresh == 0) ? 1 : m_thresh));
            if (cl) begin m_ovr = 1'b0; m_ferr = 1'b0; end
            if (rx_valid_i && rx_ferr_i) m_ferr = 1'b1;
            if (fl) mq.delete();
            else begin
                if (rd_sel && !m_rd_prev && mq.size() > 0) void'(mq.pop_front());
                if (rx_valid_i) begin
                    if (mq.size() < DEPTH) mq.push_back(rx_data_i);
                    else m_ovr = 1'b1;
                end
            end
            if (wr_ctl) begin
                m_ien = bus.m_data_i[2];
                m_thresh = int'(bus.m_data_i[13:8]);
            end
            m_rd_prev = rd_sel;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk_i);
        if (rstn) begin
            chk("m_data_o", bus.m_data_o, model_rdata());
            chk("irq_o", 32'(irq_o), 32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic fe);
        rx_data_i = d; rx_valid_i = 1'b1; rx_ferr_i = fe;
        tick();
        rx_valid_i = 1'b0; rx_ferr_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
        bus.m_sel = 1'b1; bus.m_addr = a; bus.m_rd = 1'b1;
        @(negedge clk_i);
        chk(nm, bus.m_data_o, exp);
        tick();
        bus.m_sel = 1'b0; bus.m_rd = 1'b0;
        tick();
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        bus.m_sel = 1'b1; bus.m_addr = 4'd2; bus.m_wr = 1'b1; bus.m_data_i = d;
        tick();
        bus.m_sel = 1'b0; bus.m_wr = 1'b0; bus.m_data_i = 32'd0;
    endtask

    initial begin
        bus.m_sel = 1'b0; bus.m_addr = 4'd0; bus.m_data_i = 32'd0;
        bus.m_rd = 1'b0; bus.m_wr = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rstn = 1'b1;

        chk("reset irq", 32'(irq_o), 32'd0);
        bus_read(4'd1, 32'h0000_0000, "reset status");
        bus_read(4'd2, 32'h0000_0100, "reset control");

        // Basic ordering and level
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        bus_read(4'd1, 32'h0000_0301, "status lvl3");
        bus_read(4'd0, 32'h0000_0041, "data 41");
        bus_read(4'd1, 32'h0000_0201, "status lvl2");
        bus_read(4'd0, 32'h0000_0042, "data 42");
        bus_read(4'd1, 32'h0000_0101, "status lvl1");
        bus_read(4'd0, 32'h0000_0043, "data 43");
        bus_read(4'd1, 32'h0000_0000, "status lvl0");
        bus_read(4'd0, 32'h0000_0000, "data empty");
        bus_read(4'd1, 32'h0000_0000, "status still 0");

        // Overflow
        for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
        bus_read(4'd1, 32'h0000_1007, "status full ovr");
        for (int i = 0; i < 16; i++) bus_read(4'd0, 32'(i), "drain ovr");
        ctrl_write(32'h0000_0002);
        bus_read(4'd1, 32'h0000_0000, "status ovr cleared");

        // Threshold interrupt timing
        ctrl_write(32'h0000_0404);
        bus_read(4'd2, 32'h0000_0404, "control readback");
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i), 1'b0);
        chk("irq n+1", 32'(irq_o), 32'd0);
        tick();
        chk("irq n+2", 32'(irq_o), 32'd1);
        bus.m_sel = 1'b1; bus.m_addr = 4'd0; bus.m_rd = 1'b1;
        tick();
        chk("irq after pop n+1", 32'(irq_o), 32'd1);
        bus.m_sel = 1'b0; bus.m_rd = 1'b0;
        tick();
        chk("irq after pop n+2", 32'(irq_o), 32'd0);
        ctrl_write(32'h0000_0001);
        bus_read(4'd2, 32'h0000_0000, "control thresh0");
        bus_read(4'd1, 32'h0000_0000, "status flushed");

        // Held read pops once
        push(8'h61, 1'b0); push(8'h62, 1'b0); push(8'h63, 1'b0);
        bus.m_sel = 1'b1; bus.m_addr = 4'd0; bus.m_rd = 1'b1;
        repeat (5) tick();
        bus.m_sel = 1'b0; bus.m_rd = 1'b0;
        tick();
        bus_read(4'd1, 32'h0000_0201, "held read one pop");
        ctrl_write(32'h0000_0001);

        // Push and pop on a full FIFO
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
        bus_read(4'd1, 32'h0000_1003, "status full");
        bus.m_sel = 1'b1; bus.m_addr = 4'd0; bus.m_rd = 1'b1;
        rx_valid_i = 1'b1; rx_data_i = 8'h99;
        @(negedge clk_i);
        chk("full pop old head", bus.m_data_o, 32'h0000_0020);
        tick();
        bus.m_sel = 1'b0; bus.m_rd = 1'b0; rx_valid_i = 1'b0;
        tick();
        bus_read(4'd1, 32'h0000_1003, "full push+pop no ovr");
        for (int i = 1; i < 16; i++) bus_read(4'd0, 32'(8'h20 + i), "drain full");
        bus_read(4'd0, 32'h0000_0099, "last 99");
        bus_read(4'd1, 32'h0000_0000, "empty after 99");

        // Wrap-around with framing error, then flush racing a push
        for (int i = 0; i < 10; i++) push(8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 10; i++) bus_read(4'd0, 32'(8'h70 + i), "drain pre-wrap");
        for (int i = 0; i < 10; i++) push(8'(8'h80 + i), (i == 4) ? 1'b1 : 1'b0);
        bus_read(4'd1, 32'h0000_0A09, "status wrap ferr");
        for (int i = 0; i < 10; i++) bus_read(4'd0, 32'(8'h80 + i), "drain wrap");
        push(8'h90, 1'b0); push(8'h91, 1'b0); push(8'h92, 1'b0);
        rx_valid_i = 1'b1; rx_data_i = 8'h93;
        ctrl_write(32'h0000_0001);
        rx_valid_i = 1'b0;
        bus_read(4'd1, 32'h0000_0008, "flush wins");
        push(8'hA5, 1'b0);
        bus_read(4'd0, 32'h0000_00A5, "after flush");
        ctrl_write(32'h0000_0002);
        bus_read(4'd1, 32'h0000_0000, "ferr cleared");

        // Async reset mid-operation
        push(8'h11, 1'b0); push(8'h12, 1'b0);
        ctrl_write(32'h0000_0304);
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        bus_read(4'd1, 32'h0000_0000, "status after reset");
        bus_read(4'd2, 32'h0000_0100, "control after reset");

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] d;
            if (i == 2000) rstn = 1'b0;
            if (i == 2003) rstn = 1'b1;
            rx_valid_i = ($urandom_range(0, 99) < 45);
            rx_data_i  = 8'($urandom);
            rx_ferr_i  = ($urandom_range(0, 15) == 0);
            bus.m_sel  = ($urandom_range(0, 7) != 0);
            bus.m_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            bus.m_rd   = ($urandom_range(0, 99) < 45);
            bus.m_wr   = ($urandom_range(0, 29) == 0);
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
            d[13:8] = 6'($urandom_range(0, 17));
            bus.m_data_i = d;
            tick();
        end
        rx_valid_i = 1'b0; bus.m_sel = 1'b0; bus.m_rd = 1'b0; bus.m_wr = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the SoC UART receiver and the RV32I memory bus. It captures each byte the receiver strobes out into a 2^DEPTH_LOG2-entry FIFO, so the CPU no longer loses characters while busy with USB work. It presents data, status and control registers on the standard `m_*` peripheral port, and raises a level-triggered interrupt at a programmable fill threshold. It occupies its own 256-byte slot on the CPU address decode.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16 by default); legal range 2..5.
- clk_i  in  1  system clock (48 MHz domain, same as CPU).
- rstn  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte from the UART receiver.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid in that cycle.
- rx_ferr_i  in  1  framing error (stop bit low); sampled only when rx_valid_i=1.
- m_sel  in  1  block select from the address decode.
- m_addr  in  4  word address (cpu_ad[5:2]).
- m_data_i  in  32  CPU write data.
- m_data_o  out  32  read data; combinational; 0 when m_sel=0.
- m_rd  in  1  read cycle qualifier.
- m_wr  in  1  write cycle qualifier.
- irq_o  out  1  registered interrupt request, level-sensitive.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array; wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth. level is DEPTH_LOG2+1 bits, range 0..depth.
- Push: rx_valid_i=1 and (level<depth, or a pop in the same cycle) writes the byte at wr_ptr. rx_valid_i=1 with level==depth and no pop drops the byte, leaves the FIFO unchanged and sets sticky ovr.
- Framing error: rx_valid_i & rx_ferr_i sets sticky ferr. The byte is still pushed.
- Register 0, DATA (read): {24'b0, head byte}. Returns 0 when the FIFO is empty. The pop fires on the first cycle of each contiguous interval of m_sel & m_addr==0 & m_rd; a held read pops exactly once. A pop on an empty FIFO has no effect. Writes are ignored.
- Register 1, STATUS (read-only): [0] nonempty, [1] full, [2] ovr, [3] ferr, [DEPTH_LOG2+8:8] level, all other bits 0.
- Register 2, CONTROL:
  - Write bit 0 = flush: pointers and level go to 0.
  - Write bit 1 = clear: ovr and ferr go to 0.
  - Bit 2 = ien, stored.
  - Bits [13:8] = thresh, stored; thresh==0 is treated as 1.
  - Read returns {18'b0, thresh, 5'b0, ien, 2'b0}. Bits 0 and 1 are self-clearing and read as 0.
- Other addresses read as 0; writes to them are ignored.
- irq_o is the register of ien & (level >= max(thresh,1)).

## Timing
- Reset (asynchronous): wr_ptr=rd_ptr=level=0, ovr=ferr=0, ien=0, thresh=1, irq_o=0, pop-edge tracker=0. Storage contents are not reset.
- Push at cycle N: level, nonempty and DATA update at N+1; irq_o can rise at N+2.
- Pop seen at cycle N: m_data_o shows the old head during N; rd_ptr and level update at N+1; irq_o can fall at N+2.
- Simultaneous push and pop:
  - Non-empty: level is unchanged and both pointers advance.
  - Full: the push is accepted and ovr is not set.
  - Empty: the pop is ignored and the push is accepted (level becomes 1).
- Flush and push in the same cycle: flush wins and the byte is discarded.
- Flush and clear in the same write: both take effect.
- ovr set and clear in the same cycle: set wins. The same rule applies to ferr.
- Reset asserted mid-operation: all state returns to reset values immediately. The pop-edge tracker is 0, so a read held across reset release pops once.
- Wrap-around: pointers roll from depth-1 to 0. Data ordering is preserved across the wrap.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on separate cycles, then read DATA three times with idle cycles between -> reads return 0x41, 0x42, 0x43; STATUS level reads 3, 2, 1, 0; a fourth read returns 0 and level stays 0.
- Push 17 bytes 0x00..0x10 at depth 16 -> STATUS full=1, level=16, ovr=1; draining returns 0x00..0x0F; write CONTROL=0x2 -> ovr=0.
- Write CONTROL=0x0404 (ien=1, thresh=4), push 4 bytes -> irq_o rises 2 cycles after the 4th rx_valid_i; one DATA read -> irq_o falls 2 cycles after the read.
- Hold m_sel & m_addr==0 & m_rd for 5 cycles with 3 bytes queued -> exactly one pop; level=2.
- Fill to 16, then assert rx_valid_i (0x99) in the same cycle as a DATA read -> read returns the old head, level stays 16, ovr=0, and 0x99 comes out as the last byte.
- Push 10 bytes, drain 10, then push 10 more spanning the pointer wrap with rx_ferr_i=1 on the 5th -> order is intact, ferr=1; write CONTROL=0x1 mid-stream while rx_valid_i=1 -> level=0 and the concurrent byte is discarded.
